// File: rtl/vga_pkg.sv
// Shared definitions for the VGA framebuffer fetch arbiter.
// Holds the memory address width, the arbiter FSM state encoding, the
// round-robin owner encoding and the request/grant vector bit positions.
package vga_pkg;

  localparam int unsigned AddrW = 24;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StDispWait = 2'd1,
    StHostWait = 2'd2
  } state_e;

  typedef enum logic {
    GntHost = 1'b0,
    GntDisp = 1'b1
  } grant_e;

  // Bit positions in the request/grant vectors of vga_rr_arb2.
  localparam int unsigned ReqDisp = 0;
  localparam int unsigned ReqHost = 1;

endpackage

// File: rtl/vga_rr_arb2.sv
// Two-requester round-robin decision (combinational).
// Ports:
//   req        - request vector, bit ReqDisp = display, bit ReqHost = host
//   last_grant - requester served most recently
//   gnt        - one-hot grant (all zero when nobody requests)
// A lone requester always wins; on a tie the one not served last wins.
module vga_rr_arb2
  import vga_pkg::*;
(
  input  logic [1:0] req,
  input  grant_e     last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt          = 2'b00;
    gnt[ReqDisp] = req[ReqDisp] & (~req[ReqHost] | (last_grant == GntHost));
    gnt[ReqHost] = req[ReqHost] & (~req[ReqDisp] | (last_grant == GntDisp));
  end

endmodule

// File: rtl/vga_fetch_arbiter.sv
// Arbitrates a single-word memory port between display line fetches and host writes.
// Ports:
//   clk, reset                   - clock, asynchronous active-high reset
//   line_start, line_visible     - end-of-line pulse, qualified by "next line visible"
//   frame_start                  - start-of-frame pulse (rewinds to BASE_ADDR)
//   fifo_full, pix_wr, pix_data  - line-FIFO write side
//   host_req/addr/wdata/gnt      - host write requester (holds request until host_gnt)
//   mem_req/we/addr/wdata        - memory request, held stable until mem_ack
//   mem_ack, mem_rdata           - memory response
//   underrun                     - sticky: a visible line began before the previous one finished
// All outputs are registered.
module vga_fetch_arbiter
  import vga_pkg::*;
#(
  parameter logic [AddrW-1:0] BASE_ADDR      = 24'h000000,
  parameter int unsigned      WORDS_PER_LINE = 320
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             line_start,
  input  logic             line_visible,
  input  logic             frame_start,
  input  logic             fifo_full,
  output logic             pix_wr,
  output logic [31:0]      pix_data,
  input  logic             host_req,
  input  logic [AddrW-1:0] host_addr,
  input  logic [31:0]      host_wdata,
  output logic             host_gnt,
  output logic             mem_req,
  output logic             mem_we,
  output logic [AddrW-1:0] mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic             underrun
);

  localparam int unsigned      CntW     = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam logic [CntW-1:0]  LastWord = CntW'(WORDS_PER_LINE - 1);
  localparam logic [AddrW-1:0] LineStep = AddrW'(WORDS_PER_LINE);

  state_e           state_q, state_d;
  grant_e           last_grant_q, last_grant_d;
  logic [AddrW-1:0] line_addr_q, line_addr_d;
  logic [CntW-1:0]  word_cnt_q, word_cnt_d;
  logic             disp_pending_q, disp_pending_d;
  // Set when the outstanding display fetch belongs to an abandoned line/frame.
  logic             stale_q, stale_d;

  logic             mem_req_d, mem_we_d, pix_wr_d, host_gnt_d, underrun_d;
  logic [AddrW-1:0] mem_addr_d;
  logic [31:0]      mem_wdata_d, pix_data_d;

  logic       line_go, restart, count_ack;
  logic [1:0] cand, gnt;

  assign line_go = line_start & line_visible;
  assign restart = frame_start | line_go;
  // A completed fetch only advances the line if nothing re-pointed the line meanwhile.
  assign count_ack = (state_q == StDispWait) & mem_ack & ~stale_q & ~restart;

  // No display grant on a restart cycle: the address is about to change.
  // host_gnt high means the host request still visible is the one just finished.
  always_comb begin
    cand          = 2'b00;
    cand[ReqDisp] = disp_pending_q & ~fifo_full & ~restart;
    cand[ReqHost] = host_req & ~host_gnt;
  end

  vga_rr_arb2 u_arb (
    .req        (cand),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    line_addr_d    = line_addr_q;
    word_cnt_d     = word_cnt_q;
    disp_pending_d = disp_pending_q;
    stale_d        = stale_q;
    mem_req_d      = mem_req;
    mem_we_d       = mem_we;
    mem_addr_d     = mem_addr;
    mem_wdata_d    = mem_wdata;
    pix_wr_d       = 1'b0;
    pix_data_d     = pix_data;
    host_gnt_d     = 1'b0;
    underrun_d     = underrun;

    case (state_q)
      StIdle: begin
        if (gnt[ReqDisp]) begin
          state_d      = StDispWait;
          last_grant_d = GntDisp;
          stale_d      = 1'b0;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = line_addr_q + AddrW'(word_cnt_q);
        end else if (gnt[ReqHost]) begin
          state_d      = StHostWait;
          last_grant_d = GntHost;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b1;
          mem_addr_d   = host_addr;
          mem_wdata_d  = host_wdata;
        end
      end
      StDispWait: begin
        if (restart) stale_d = 1'b1;
        if (mem_ack) begin
          state_d    = StIdle;
          mem_req_d  = 1'b0;
          pix_wr_d   = 1'b1;
          pix_data_d = mem_rdata;
        end
      end
      StHostWait: begin
        if (mem_ack) begin
          state_d    = StIdle;
          mem_req_d  = 1'b0;
          host_gnt_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Line bookkeeping: fetch completion, then frame_start, then line_start.
    if (count_ack) begin
      if (word_cnt_q == LastWord) begin
        disp_pending_d = 1'b0;
        word_cnt_d     = '0;
        line_addr_d    = line_addr_q + LineStep;
      end else begin
        word_cnt_d = word_cnt_q + CntW'(1);
      end
    end
    if (frame_start) begin
      line_addr_d    = BASE_ADDR;
      word_cnt_d     = '0;
      disp_pending_d = 1'b0;
    end
    if (line_go) begin
      // Previous line unfinished: skip the rest of it.
      if (disp_pending_q && !frame_start) begin
        underrun_d  = 1'b1;
        line_addr_d = line_addr_q + LineStep;
      end
      disp_pending_d = 1'b1;
      word_cnt_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      last_grant_q   <= GntHost;
      line_addr_q    <= BASE_ADDR;
      word_cnt_q     <= '0;
      disp_pending_q <= 1'b0;
      stale_q        <= 1'b0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      pix_wr         <= 1'b0;
      pix_data       <= '0;
      host_gnt       <= 1'b0;
      underrun       <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      line_addr_q    <= line_addr_d;
      word_cnt_q     <= word_cnt_d;
      disp_pending_q <= disp_pending_d;
      stale_q        <= stale_d;
      mem_req        <= mem_req_d;
      mem_we         <= mem_we_d;
      mem_addr       <= mem_addr_d;
      mem_wdata      <= mem_wdata_d;
      pix_wr         <= pix_wr_d;
      pix_data       <= pix_data_d;
      host_gnt       <= host_gnt_d;
      underrun       <= underrun_d;
    end
  end

endmodule

// File: doc/vga_fetch_arbiter.md
VGA_FETCH_ARBITER -- requirements
Module: vga_fetch_arbiter

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 24'h000000: framebuffer word address of line 0.
REQ-002 SHALL have parameter WORDS_PER_LINE, default 320: 32-bit words fetched per visible line (1280 px, 4 px/word).
REQ-003 SHALL have port clk  input  1: clock; reset  input  1: reset, asynchronous, active-high.
REQ-004 SHALL have ports line_start  input  1 (one-cycle end-of-line pulse from the hsync generator) and line_visible  input  1 (qualifies line_start: next line is visible).
REQ-005 SHALL have port frame_start  input  1: one-cycle pulse at start of frame.
REQ-006 SHALL have ports fifo_full  input  1, pix_wr  output  1, pix_data  output  32: line-FIFO write side.
REQ-007 SHALL have ports host_req  input  1, host_addr  input  24, host_wdata  input  32, host_gnt  output  1: host write requester.
REQ-008 SHALL have ports mem_req  output  1, mem_we  output  1, mem_addr  output  24, mem_wdata  output  32, mem_ack  input  1, mem_rdata  input  32: single-word memory port.
REQ-009 SHALL have port underrun  output  1: sticky display-deadline-miss flag.

Function
REQ-010 SHALL implement states IDLE, DISP_WAIT, HOST_WAIT; every output registered.
REQ-011 line_start with line_visible=1 SHALL set disp_pending and clear word count to 0; line_start with line_visible=0 SHALL be ignored.
REQ-012 In IDLE, candidates: display (disp_pending=1 and fifo_full=0), host (host_req=1).
REQ-013 Only one candidate: SHALL serve it; both: SHALL grant the one not served last (round-robin; last_grant resets to host, so display wins first).
REQ-014 Display grant: next cycle mem_req=1, mem_we=0, mem_addr=line_addr+word_cnt; state DISP_WAIT.
REQ-015 Host grant: next cycle mem_req=1, mem_we=1, mem_addr=host_addr, mem_wdata=host_wdata (captured at grant); state HOST_WAIT.
REQ-016 mem_req, mem_we, mem_addr, mem_wdata SHALL stay stable until the cycle mem_ack=1; mem_req SHALL drop the cycle after ack; state returns to IDLE; at most one transaction outstanding.
REQ-017 Ack in DISP_WAIT: cycle after ack pix_wr=1 for one cycle, pix_data=mem_rdata sampled at ack; word_cnt increments.
REQ-018 Ack of word WORDS_PER_LINE-1: SHALL clear disp_pending and add WORDS_PER_LINE to line_addr (24-bit, wrap modulo 2^24).
REQ-019 Ack in HOST_WAIT: host_gnt=1 for one cycle the cycle after ack; host holds host_req/addr/wdata until host_gnt.
REQ-020 Visible line_start while disp_pending=1: underrun SHALL set; line_addr SHALL advance by WORDS_PER_LINE; word_cnt SHALL restart at 0; any outstanding transaction completes normally first.
REQ-021 frame_start SHALL load line_addr=BASE_ADDR, clear word_cnt and disp_pending; outstanding transaction completes, its pix_wr still issued.
REQ-022 frame_start and line_start same cycle: frame_start applied first, then line_start, so fetch begins at BASE_ADDR with no underrun.
REQ-023 underrun SHALL clear only on reset.
REQ-024 fifo_full=1 SHALL stall only new display grants, never an outstanding one; host grants continue.

Reset
REQ-025 reset SHALL force state=IDLE, line_addr=BASE_ADDR, word_cnt=0, disp_pending=0, last_grant=host, and mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, pix_wr=0, pix_data=0, host_gnt=0, underrun=0.
REQ-026 Reset mid-transaction SHALL abandon it; no host_gnt or pix_wr for it afterwards.

Structure
REQ-027 State encodings and the 24-bit address width SHALL live in shared package vga_pkg.
REQ-028 Round-robin decision SHALL be sub-module vga_rr_arb2 (2 requests, last_grant input, one-hot grant).

Verification
REQ-029 Single visible line_start, fifo_full=0, mem_ack 1 cycle after each req, no host -> 320 reads at 0x000000..0x00013F, 320 pix_wr, underrun=0.
REQ-030 host_req held with display pending -> grants alternate D,H,D,H; host_gnt after each host ack; write addr/data match host_addr/host_wdata.
REQ-031 Second visible line_start after 100 words -> underrun=1, next read address 0x000140, word_cnt 0.
REQ-032 fifo_full=1 for 50 cycles mid-line with host_req -> no new display reqs, host writes proceed, display resumes at same address.
REQ-033 frame_start+line_start same cycle after 3 lines -> first read at BASE_ADDR, underrun unchanged.
REQ-034 reset asserted while mem_req=1 in DISP_WAIT -> all outputs 0 next edge, no pix_wr after release.
